// File: rtl/threshold_arbiter.sv
// Shares one Threshold detector among NUM_CH channel counters. Each channel has a
// one-entry holding slot, and the slots are served round-robin. Results return as per-channel detect pulses.

module threshold_arbiter_slot #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap,
  input  logic [W-1:0] val,
  input  logic         gnt,
  input  logic         ovr_clr,
  output logic         full,
  output logic [W-1:0] data,
  output logic         ovr
);
  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         ovr_q, ovr_d;

  // A grant frees the slot in the same cycle, so a capture that coincides with a grant refills the slot.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    ovr_d  = ovr_clr ? 1'b0 : ovr_q;
    if (gnt) full_d = 1'b0;
    if (cap) begin
      if (full_q && !gnt) begin
        ovr_d = 1'b1;
      end else begin
        full_d = 1'b1;
        data_d = val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      ovr_q  <= ovr_d;
    end
  end

  assign full = full_q;
  assign data = data_q;
  assign ovr  = ovr_q;
endmodule

module threshold_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int W       = 10,
  parameter int DET_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH*W-1:0] ch_cntr,
  input  logic [NUM_CH-1:0]   ch_valid,
  input  logic                ovr_clr,
  output logic [W-1:0]        th_cntr,
  output logic                th_valid,
  input  logic                th_detect,
  output logic [NUM_CH-1:0]   detect,
  output logic [NUM_CH-1:0]   ch_overrun,
  output logic                busy
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = 4;
  localparam logic [IW:0] NCH = (IW+1)'(NUM_CH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [NUM_CH-1:0][W-1:0] slot_data;
  logic [NUM_CH-1:0]        slot_full;
  logic [NUM_CH-1:0]        gnt_vec;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [W-1:0]      th_cntr_q, th_cntr_d;
  logic              th_valid_q, th_valid_d;
  logic [NUM_CH-1:0] detect_q, detect_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   pick_sum;
  logic          grant_en;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    assign gnt_vec[g] = grant_en && (pick_idx == IW'(g));
    threshold_arbiter_slot #(.W(W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .cap     (ch_valid[g]),
      .val     (ch_cntr[g*W +: W]),
      .gnt     (gnt_vec[g]),
      .ovr_clr (ovr_clr),
      .full    (slot_full[g]),
      .data    (slot_data[g]),
      .ovr     (ch_overrun[g])
    );
  end

  // Round-robin pick: first full slot at or after ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pick_sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (pick_sum >= NCH) pick_sum = pick_sum - NCH;
      if (!pick_found && slot_full[pick_sum[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_sum[IW-1:0];
      end
    end
  end

  assign grant_en = (state_q == S_IDLE) && pick_found;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    th_cntr_d  = th_cntr_q;
    th_valid_d = 1'b0;
    detect_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          th_cntr_d  = slot_data[pick_idx];
          th_valid_d = 1'b1;
          gnt_d      = pick_idx;
          ptr_d      = (pick_idx == IW'(NUM_CH-1)) ? '0 : pick_idx + 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // cnt_q reaches DET_LAT-1 exactly DET_LAT cycles after the issue cycle.
        if (cnt_q == CW'(DET_LAT-1)) begin
          if (th_detect) detect_d[gnt_q] = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ptr_q      <= '0;
      th_cntr_q  <= '0;
      th_valid_q <= 1'b0;
      detect_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      th_cntr_q  <= th_cntr_d;
      th_valid_q <= th_valid_d;
      detect_q   <= detect_d;
    end
  end

  assign th_cntr  = th_cntr_q;
  assign th_valid = th_valid_q;
  assign detect   = detect_q;
  assign busy     = (state_q != S_IDLE) || (|slot_full);
endmodule

// File: doc/threshold_arbiter.md
# threshold_arbiter

Time-shares a single `Threshold` detector between `NUM_CH` microphone channel counters.
- Each channel's counter sample is captured into a one-entry holding slot.
- Slots are served round-robin: one sample at a time goes to the shared detector, and its result comes back as a per-channel detect pulse.
- The block sits between the per-channel counter front-ends and the one `Threshold` instance, replacing one detector per channel.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting channels (2..8).
- `W`, 10: counter width; matches `Threshold` `cntr`.
- `DET_LAT`, 2: cycles from the `th_valid` cycle to the cycle in which `th_detect` is valid for that sample (1..15).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset; asynchronous, active-low.
- `ch_cntr`  in  `NUM_CH*W`: channel i sample at bits `[i*W +: W]`.
- `ch_valid`  in  `NUM_CH`: one-cycle capture strobe per channel.
- `ovr_clr`  in  1: clears all `ch_overrun` bits (synchronous).
- `th_cntr`  out  `W`: sample driven to the shared `Threshold.cntr`.
- `th_valid`  out  1: drives `Threshold.cntr_valid`; one-cycle pulse per issued sample.
- `th_detect`  in  1: `Threshold.detect`.
- `detect`  out  `NUM_CH`: one-cycle pulse on the bit of the channel whose sample produced `th_detect`=1.
- `ch_overrun`  out  `NUM_CH`: sticky; a sample was dropped for that channel.
- `busy`  out  1: high whenever state ≠ IDLE or any slot is full.

## Operation
Holding slots (one per channel): a full flag plus a W-bit value.
- Capture: `ch_valid[i]`=1 in a cycle writes `ch_cntr[i]` into slot i and sets full.
- Drop: if slot i is already full and is not being granted in that cycle, the new sample is dropped, the old value is kept, and `ch_overrun[i]` is set.
- Simultaneous capture and grant of slot i: the granted (old) value is issued, and the new value refills the slot. No overrun is flagged.
- `ovr_clr` together with a new overrun event in the same cycle: the overrun wins (bit ends up set).

State machine:
- IDLE: if any slot is full, grant the first full slot searching upward from `ptr` and wrapping modulo `NUM_CH`. Then:
  - register `th_cntr` ← slot value and `th_valid` ← 1;
  - clear that slot's full flag;
  - `gnt` ← index, `ptr` ← index+1 (wrap to 0 after `NUM_CH`-1);
  - go to ISSUE.
  - If no slot is full, stay in IDLE.
- ISSUE (`th_valid`=1 this cycle): clear wait counter; go to WAIT.
- WAIT: increment counter. In the cycle DET_LAT after the ISSUE cycle, sample `th_detect`. If it is 1, register `detect[gnt]` ← 1 for the next cycle. Go to IDLE.
- `th_cntr` holds the last issued value between issues. `th_valid` is never high two consecutive cycles.
- The block does not compare values; thresholding is entirely inside `Threshold`.

## Timing
Reset values (`rst`=0, asynchronous, regardless of `clk`):
- `th_cntr`=0, `th_valid`=0, `detect`=0, `ch_overrun`=0, `busy`=0.
- All slots empty, `ptr`=0, state IDLE.
- Reset asserted mid-WAIT discards the outstanding result; no `detect` pulse follows deassertion.

Cycle timing:
- Capture latency: `ch_valid` in cycle C → slot full from C+1 → earliest `th_valid` in C+2.
- Result latency: `th_valid` in cycle T → `th_detect` sampled in T+DET_LAT → `detect[gnt]` high in T+DET_LAT+1 for exactly one cycle.
- IDLE is re-entered in T+DET_LAT+1, so the next `th_valid` occurs no earlier than T+DET_LAT+2. Sustained throughput is one sample per DET_LAT+2 cycles.
- A `detect` pulse may coincide with the next grant decision. This is legal.

## Test plan
1. Single sample (DET_LAT=2): channel 1 gets `ch_valid` with 600 at cycle 10 and the stub returns `th_detect`=1.
   → `th_valid` at cycle 12 with `th_cntr`=600; `detect`=4'b0010 at cycle 15 only.
2. Simultaneous arrival: all four channels captured at once with 400/600/800/900 after reset.
   → issue order ch0, ch1, ch2, ch3; `th_valid` spacing exactly 4 cycles.
   → a stub detecting only values >700 gives pulses on ch2 then ch3 only.
3. Round-robin fairness: after ch2 is granted, ch0 and ch3 become full.
   → ch3 is issued before ch0.
4. Overrun: ch0 receives 200 then 100 while ch1 is in WAIT and ch0 is not yet granted.
   → 200 is issued, `ch_overrun[0]`=1 and stays 1; pulse `ovr_clr` → 0.
5. Reset mid-operation: drop `rst` during WAIT with `th_detect`=1 pending.
   → all outputs 0 immediately; after release, no `detect` pulse and `busy`=0.
6. Refill on grant: `ch_valid[3]` carrying 700 in the same cycle slot 3 (holding 800) is granted.
   → 800 is issued, then 700 is issued next; no overrun.
